// File: rtl/nibble_serial_adder_ctrl.sv
// rtl/nibble_serial_adder_ctrl.sv - WIDTH-bit adder built from one reused 4-bit lookahead slice
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       c3,
    output logic       cout
);
    logic [3:0] p;
    logic [3:0] g;
    logic       c1;
    logic       c2;

    assign p  = a ^ b;
    assign g  = a & b;
    assign c1 = g[0] | (p[0] & cin);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);
    assign s  = p ^ {c3, c2, c1, cin};
endmodule

module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);
    localparam int NIB = WIDTH / 4;
    localparam int IDW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDW-1:0] LAST = IDW'(NIB - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [IDW-1:0]   idx;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [3:0] nib_s;
    logic       nib_c3;
    logic       nib_cout;

    cla4_slice u_slice (
        .a    (a_q[4*idx +: 4]),
        .b    (b_q[4*idx +: 4]),
        .cin  (carry_q),
        .s    (nib_s),
        .c3   (nib_c3),
        .cout (nib_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            idx         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        carry_q    <= cin;
                        idx        <= '0;
                        state      <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    sum_q[4*idx +: 4] <= nib_s;
                    carry_q           <= nib_cout;
                    if (idx == LAST) begin
                        // Carry into the top bit comes from the last slice's internal C3.
                        cout_q      <= nib_cout;
                        ovf_q       <= nib_c3 ^ nib_cout;
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb/tb_nibble_serial_adder_ctrl.sv - directed self-checking bench for nibble_serial_adder_ctrl
module tb_nibble_serial_adder_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        busy;

    int errors = 0;
    int checks = 0;

    nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation, optionally disturbing inputs during RUN; leaves the bench in DONE.
    task automatic start_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                            input logic vc, input bit disturb);
        int n;
        check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
        a = va; b = vb; cin = vc; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, " busy"}, 32'(busy), 32'd1);
        n = 0;
        while (!out_valid && n < 20) begin
            if (disturb) begin
                a = 16'hDEAD; b = 16'hBEEF; cin = ~vc; in_valid = 1'b1;
                check({tag, " in_ready run"}, 32'(in_ready), 32'd0);
            end
            tick();
            n++;
        end
        in_valid = 1'b0;
        check({tag, " latency"}, 32'(n), 32'd4);
    endtask

    task automatic check_result(input string tag, input logic [15:0] es, input logic ec,
                                input logic eo);
        check({tag, " out_valid"}, 32'(out_valid), 32'd1);
        check({tag, " sum"}, 32'(sum), 32'(es));
        check({tag, " cout"}, 32'(cout), 32'(ec));
        check({tag, " ovf"}, 32'(ovf), 32'(eo));
    endtask

    task automatic op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                      input logic vc, input logic [15:0] es, input logic ec, input logic eo,
                      input bit disturb);
        start_op(tag, va, vb, vc, disturb);
        check_result(tag, es, ec, eo);
        tick();
        check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
        tick();
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst sum", 32'(sum), 32'd0);
        check("rst cout", 32'(cout), 32'd0);
        check("rst ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        tick();

        op("basic",   16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
        op("ripple",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        op("ovf_neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        op("cin",     16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
        op("hold",    16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        check("hold sum kept", 32'(sum), 32'h0000);
        check("hold cout kept", 32'(cout), 32'd1);

        out_ready = 1'b0;
        start_op("bp", 16'h9ABC, 16'h6543, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_result("bp hold", 16'hFFFF, 1'b0, 1'b0);
            check("bp in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("bp exit out_valid", 32'(out_valid), 32'd0);
        op("bp next", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0);

        a = 16'h1234; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort in_ready", 32'(in_ready), 32'd1);
        check("abort sum", 32'(sum), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        op("post_rst", 16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
Sequential controller that performs WIDTH-bit addition by reusing one 4-bit carry-lookahead slice. The slice computes per-bit propagate (A^B) and generate (A&B), and produces the carry out as G | (P & Cin).
- The controller accepts operands through a valid/ready handshake.
- It feeds one nibble per cycle, least significant nibble first, through the slice.
- It holds the inter-nibble carry in a register.
- It presents the full sum, carry-out and signed overflow through a second valid/ready handshake.

The slice is instantiated inside this block. It trades latency for area against a full-width ripple or lookahead adder.

Parameters:
WIDTH, 16, operand and sum width in bits; must be a multiple of 4 and at least 4. NIB = WIDTH/4 nibbles.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operands a, b, cin are valid.
in_ready  output  1  block can accept operands; high only in IDLE.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry into bit 0.
out_valid  output  1  sum, cout and ovf are valid; high only in DONE.
out_ready  input  1  consumer accepts the result.
sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
cout  output  1  carry out of bit WIDTH-1.
ovf  output  1  signed overflow: carry into bit WIDTH-1 XOR cout.
busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n low, asynchronous) sets state to IDLE and clears all internal state:
  - Cleared registers: operand registers, carry register, nibble index, sum register, cout, ovf.
  - Output values during and after reset: in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On a rising edge with in_valid=1: capture a, b and cin; set carry register = cin; set nibble index = 0; go to RUN.
  - a, b and cin are sampled only on that edge; later input changes have no effect.
- RUN:
  - Each cycle, the slice adds nibble[idx] of the captured a, nibble[idx] of the captured b, and the carry register.
  - On the edge:
    - Write the 4-bit slice result into sum[4*idx+3 : 4*idx].
    - Load the slice carry-out into the carry register.
    - When idx = NIB-1, record the carry into bit 3 of that slice (= p3... internal carry C3) for ovf.
  - idx increments each cycle.
  - On the edge where idx = NIB-1: set cout = slice carry-out, set ovf = C3 XOR slice carry-out, go to DONE.
- Latency: operands accepted on edge k → out_valid high after edge k+NIB (4 cycles for WIDTH=16).
- DONE:
  - out_valid=1. sum, cout and ovf are held stable while out_ready=0.
  - On an edge with out_ready=1: go to IDLE. out_valid drops.
  - sum, cout and ovf keep their last values until the next acceptance. They are not cleared.
- Throughput: no overlap. New operands are accepted no earlier than the cycle after DONE exits, giving a minimum period of NIB+2 cycles per operation.
- in_valid while not in IDLE is ignored; the operands are not queued.
- During RUN, the partially written sum is visible on the sum port but is undefined for consumers, because out_valid=0.
- Reset asserted mid-RUN or mid-DONE: immediate abort to reset values. No result is delivered.
- WIDTH=4: RUN lasts exactly one cycle.
- All arithmetic is unsigned modulo 2^WIDTH. ovf interprets a, b and sum as two's complement.

Test Plan:
1. WIDTH=16, a=0x1234, b=0x4321, cin=0, out_ready=1 → out_valid exactly 4 cycles after acceptance; sum=0x5555, cout=0, ovf=0.
2. a=0xFFFF, b=0x0001, cin=0 → the carry ripples across all four nibble cycles; sum=0x0000, cout=1, ovf=0.
3. Overflow cases:
   - a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, cout=0, ovf=1.
   - a=0x8000, b=0x8000, cin=0 → sum=0x0000, cout=1, ovf=1.
4. Carry-in and hold behaviour:
   - a=0x0000, b=0x0000, cin=1 → sum=0x0001, cout=0.
   - Change a, b and in_valid during RUN → result unchanged, in_ready stays 0.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid, sum, cout and ovf stable throughout; in_ready=0. Then raise out_ready=1 → IDLE on the next edge; a new operation is accepted on the following edge.
6. Reset mid-operation: assert rst_n=0 two cycles into RUN → out_valid=0, in_ready=1, sum=0 immediately. After release, a=0x00FF, b=0x0F01 completes with sum=0x1000.
